// File: rtl/gray_sync_pkg.sv
// Shared helpers and constants for the multi-channel Gray pointer synchronizer.
// Functions work on a wide container; zero-extended pointers convert correctly.
package gray_sync_pkg;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int ERR_CNT_W       = 8;
  localparam int PTR_MAX_W       = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic popcount_gt1(input ptr_t v);
    return (v & (v - ptr_t'(1))) != '0;
  endfunction
endpackage

// File: rtl/gray_sync_chan.sv
// One pointer channel: sync chain, aligned output register, change pulse and
// combinational Gray-integrity event (registered by the top).
module gray_sync_chan
  import gray_sync_pkg::*;
#(
  parameter int W           = 7,
  parameter int SYNC_STAGES = 2,
  parameter int CHECK_EN    = 1
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic [W-1:0] rptr,
  input  logic         primed,
  output logic [W-1:0] wq_rptr,
  output logic [W-1:0] wq_rptr_bin,
  output logic         ptr_upd,
  output logic         err_evt
);
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] last_q, diff;

  assign last_q = sync_q[SYNC_STAGES-1];
  assign diff   = last_q ^ wq_rptr;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      sync_q      <= '0;
      wq_rptr     <= '0;
      wq_rptr_bin <= '0;
      ptr_upd     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rptr};
      wq_rptr     <= last_q;
      wq_rptr_bin <= W'(gray2bin(ptr_t'(last_q)));
      ptr_upd     <= (diff != '0) && primed;
    end
  end

  generate
    if (CHECK_EN != 0) begin : g_chk
      assign err_evt = primed && popcount_gt1(ptr_t'(diff));
    end else begin : g_nochk
      assign err_evt = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/gray_ptr_sync_multi.sv
// NUM_CH Gray pointers synchronized into wclk, with binary view, change pulse,
// sticky multi-bit-change flags and a saturating shared error counter.
module gray_ptr_sync_multi
  import gray_sync_pkg::*;
#(
  parameter int ADDRSIZE    = 6,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 1,
  parameter int CHECK_EN    = 1
) (
  input  logic                           wclk,
  input  logic                           wrst,
  input  logic [NUM_CH*(ADDRSIZE+1)-1:0] rptr,
  input  logic                           err_clr,
  output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rptr,
  output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rptr_bin,
  output logic [NUM_CH-1:0]              ptr_upd,
  output logic [NUM_CH-1:0]              gray_err,
  output logic [ERR_CNT_W-1:0]           err_cnt
);
  localparam int W = ADDRSIZE + 1;
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("gray_ptr_sync_multi: SYNC_STAGES must be 2..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
      $error("gray_ptr_sync_multi: NUM_CH must be 1..8");
    end
  endgenerate

  // Primes after reset so a pointer already nonzero at release is not a change.
  logic [2:0] prime_cnt;
  logic       primed;
  assign primed = (prime_cnt == PRIME_LAST);

  always_ff @(posedge wclk) begin
    if (wrst)         prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + 3'd1;
  end

  logic [NUM_CH-1:0] err_evt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gray_sync_chan #(
      .W           (W),
      .SYNC_STAGES (SYNC_STAGES),
      .CHECK_EN    (CHECK_EN)
    ) u_chan (
      .wclk        (wclk),
      .wrst        (wrst),
      .rptr        (rptr[c*W +: W]),
      .primed      (primed),
      .wq_rptr     (wq_rptr[c*W +: W]),
      .wq_rptr_bin (wq_rptr_bin[c*W +: W]),
      .ptr_upd     (ptr_upd[c]),
      .err_evt     (err_evt[c])
    );
  end

  generate
    if (CHECK_EN != 0) begin : g_cnt
      logic [3:0]           evt_sum;
      logic [ERR_CNT_W-1:0] cnt_base;
      logic [ERR_CNT_W:0]   cnt_sum;

      always_comb begin
        evt_sum = '0;
        for (int c = 0; c < NUM_CH; c++) evt_sum = evt_sum + {3'b0, err_evt[c]};
      end

      // Clear applies first, so events landing with err_clr still count.
      assign cnt_base = err_clr ? '0 : err_cnt;
      assign cnt_sum  = {1'b0, cnt_base} + (ERR_CNT_W+1)'(evt_sum);

      always_ff @(posedge wclk) begin
        if (wrst) begin
          gray_err <= '0;
          err_cnt  <= '0;
        end else begin
          gray_err <= (gray_err & ~{NUM_CH{err_clr}}) | err_evt;
          err_cnt  <= cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
        end
      end
    end else begin : g_nocnt
      assign gray_err = '0;
      assign err_cnt  = '0;
    end
  endgenerate
endmodule

// File: tb/tb_gray_ptr_sync_multi.sv
// Directed bench: 4 channels, 2 sync stages, hand-computed expectations.
module tb_gray_ptr_sync_multi;
  import gray_sync_pkg::*;

  localparam int AS = 6;
  localparam int W  = AS + 1;
  localparam int SS = 2;
  localparam int NC = 4;

  logic            wclk = 1'b0;
  logic            wrst;
  logic            err_clr;
  logic [NC*W-1:0] rptr;
  logic [NC*W-1:0] wq_rptr;
  logic [NC*W-1:0] wq_rptr_bin;
  logic [NC-1:0]   ptr_upd;
  logic [NC-1:0]   gray_err;
  logic [7:0]      err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  gray_ptr_sync_multi #(
    .ADDRSIZE    (AS),
    .SYNC_STAGES (SS),
    .NUM_CH      (NC),
    .CHECK_EN    (1)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .rptr        (rptr),
    .err_clr     (err_clr),
    .wq_rptr     (wq_rptr),
    .wq_rptr_bin (wq_rptr_bin),
    .ptr_upd     (ptr_upd),
    .gray_err    (gray_err),
    .err_cnt     (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    rptr[c*W +: W] = v;
  endtask

  function automatic logic [W-1:0] g7(input int i);
    return W'(bin2gray(ptr_t'(i)));
  endfunction

  function automatic logic [31:0] wq(input int c);
    return 32'(wq_rptr[c*W +: W]);
  endfunction

  function automatic logic [31:0] wb(input int c);
    return 32'(wq_rptr_bin[c*W +: W]);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wq"},   32'(wq_rptr),     32'd0);
    chk({tag, "_bin"},  32'(wq_rptr_bin), 32'd0);
    chk({tag, "_upd"},  32'(ptr_upd),     32'd0);
    chk({tag, "_gerr"}, 32'(gray_err),    32'd0);
    chk({tag, "_cnt"},  32'(err_cnt),     32'd0);
  endtask

  initial begin
    wrst = 1'b1; err_clr = 1'b0; rptr = '0;

    // Reset, then release with a nonzero pointer already present
    step(3);
    chk_all_zero("rst");
    set_ch(0, 7'b0000011);
    wrst = 1'b0;
    step(2);
    chk("lat_early", wq(0), 32'd0);
    step(1);
    chk("lat_wq",   wq(0), 32'h03);
    chk("lat_bin",  wb(0), 32'd2);
    chk("lat_upd",  32'(ptr_upd),  32'd0);
    chk("lat_gerr", 32'(gray_err), 32'd0);
    step(2);
    chk("prime_upd", 32'(ptr_upd), 32'd0);

    // Count sweep from binary 3 up to 127, then wrap to 0
    for (int i = 3; i <= 128; i++) begin
      set_ch(0, g7(i % 128));
      step(3);
      chk("sweep_g",   wq(0), 32'(g7(i % 128)));
      chk("sweep_b",   wb(0), 32'(i % 128));
      chk("sweep_upd", 32'(ptr_upd), 32'b0001);
      step(1);
      chk("sweep_idle", 32'(ptr_upd), 32'd0);
    end
    chk("sweep_gerr", 32'(gray_err), 32'd0);
    chk("sweep_cnt",  32'(err_cnt),  32'd0);

    // Two-bit jump on channel 0, then clear
    set_ch(0, 7'b0000011);
    step(2);
    chk("jump_early", 32'(gray_err), 32'd0);
    step(1);
    chk("jump_gerr", 32'(gray_err), 32'b0001);
    chk("jump_cnt",  32'(err_cnt),  32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("clr_gerr", 32'(gray_err), 32'd0);
    chk("clr_cnt",  32'(err_cnt),  32'd0);

    // Simultaneous jumps on channels 1 and 3
    set_ch(1, 7'b0000011);
    set_ch(3, 7'b0000011);
    step(3);
    chk("mc_cnt",  32'(err_cnt),  32'd2);
    chk("mc_gerr", 32'(gray_err), 32'b1010);
    chk("mc_upd",  32'(ptr_upd),  32'b1010);
    chk("mc_wq0",  wq(0), 32'h03);
    chk("mc_wq2",  wq(2), 32'h00);
    chk("mc_bin1", wb(1), 32'd2);

    // 300 two-bit toggles on channel 2 saturate the counter
    for (int k = 0; k < 300; k++) begin
      set_ch(2, (k % 2 == 0) ? 7'b0000011 : 7'b0000000);
      step(1);
    end
    step(4);
    chk("sat_cnt",  32'(err_cnt),  32'd255);
    chk("sat_gerr", 32'(gray_err), 32'b1110);

    // err_clr lands on the same edge as a new event
    set_ch(2, 7'b0000011);
    step(2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("coll_cnt",  32'(err_cnt),  32'd1);
    chk("coll_gerr", 32'(gray_err), 32'b0100);

    // Reset while channel 0 increments
    for (int k = 3; k <= 7; k++) begin
      set_ch(0, g7(k));
      step(1);
    end
    set_ch(0, g7(8));
    wrst = 1'b1;
    step(1);
    chk_all_zero("mid_rst");
    set_ch(0, g7(9));
    wrst = 1'b0;
    for (int e = 1; e <= SS + 3; e++) begin
      step(1);
      chk("post_upd",  32'(ptr_upd),  32'd0);
      chk("post_gerr", 32'(gray_err), 32'd0);
      chk("post_cnt",  32'(err_cnt),  32'd0);
    end
    chk("post_wq", 32'(wq_rptr), 32'(rptr));
    chk("post_b0", wb(0), 32'd9);
    set_ch(0, g7(10));
    step(3);
    chk("post_step_upd", 32'(ptr_upd), 32'b0001);
    chk("post_step_bin", wb(0), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
